// File: rtl/output_ram_collector_pkg.sv
// Shared constants and FSM encoding for the output RAM collector.
// Storage is 8 words of 16 bits, addressed by 3 bits.
package output_ram_collector_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/output_ram_collector_mem.sv
// collector_mem: 8x16 register file, one synchronous write port, two async read ports.
// Write lands at the clock edge; reads are combinational. No backpressure.
// A clear pulse zeroes every word except the one written in the same cycle.
module collector_mem
  import output_ram_collector_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              clr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we && waddr == ADDR_W'(i)) mem[i] <= wdata;
        else if (clr)                  mem[i] <= '0;
      end
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/output_ram_collector.sv
// Output-RAM responder: collects accelerator writes, then drains all words as a valid/ready stream.
// Host reads return one cycle later; drain is one word per cycle and holds while ready is low.
// Optional OUTPUT_RAM_COLLECTOR_OVERWRITE_DETECT_EN adds a sticky double-write flag.
module output_ram_collector #(
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       dut__dom__address,
  input  logic [15:0]      dut__dom__data,
  input  logic             dut__dom__enable,
  input  logic             dut__dom__write,
  output logic [15:0]      dom__dut__data,
  input  logic             dut__xxx__finish,
  output logic             col__xxx__valid,
  output logic [15:0]      col__xxx__data,
  output logic [2:0]       col__xxx__index,
  output logic             col__xxx__last,
  input  logic             xxx__col__ready,
  output logic             col__xxx__done,
  output logic [DEPTH-1:0] col__xxx__written_mask,
`ifdef OUTPUT_RAM_COLLECTOR_OVERWRITE_DETECT_EN
  output logic             col__xxx__overwrite_err,
`endif
  output logic             col__xxx__drop_err
);

  import output_ram_collector_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [DEPTH-1:0]  mask, mask_nxt;
  logic              mem_we, mem_clr, drop_set;
  logic              wr_req, rd_req, last_idx;
  logic [DATA_W-1:0] host_rdata, drain_rdata;

  assign wr_req   = dut__dom__enable & dut__dom__write;
  assign rd_req   = dut__dom__enable & ~dut__dom__write;
  assign last_idx = (idx == ADDR_W'(DEPTH - 1));

  collector_mem u_mem (
    .clock   (clock),
    .reset   (reset),
    .we      (mem_we),
    .clr     (mem_clr),
    .waddr   (dut__dom__address),
    .wdata   (dut__dom__data),
    .raddr_a (dut__dom__address),
    .rdata_a (host_rdata),
    .raddr_b (idx),
    .rdata_b (drain_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_COLLECT;
      idx   <= '0;
      mask  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      mask  <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mask_nxt  = mask;
    mem_we    = 1'b0;
    mem_clr   = 1'b0;
    drop_set  = 1'b0;
    case (state)
      ST_COLLECT: begin
        // A same-cycle write still commits; the drain reads it from the next cycle on.
        if (wr_req) begin
          mem_we                       = 1'b1;
          mask_nxt[dut__dom__address]  = 1'b1;
        end
        if (dut__xxx__finish) begin
          state_nxt = ST_DRAIN;
          idx_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        drop_set = wr_req;
        if (xxx__col__ready) begin
          if (last_idx) state_nxt = ST_DONE;
          else          idx_nxt   = idx + 1'b1;
        end
      end
      ST_DONE: begin
        // First write of a new round wipes the previous result set.
        if (wr_req) begin
          mem_we                      = 1'b1;
          mem_clr                     = 1'b1;
          mask_nxt                    = '0;
          mask_nxt[dut__dom__address] = 1'b1;
          state_nxt                   = ST_COLLECT;
        end
      end
      default: state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dom__dut__data     <= '0;
      col__xxx__drop_err <= 1'b0;
    end else begin
      if (rd_req)   dom__dut__data     <= host_rdata;
      if (drop_set) col__xxx__drop_err <= 1'b1;
    end
  end

`ifdef OUTPUT_RAM_COLLECTOR_OVERWRITE_DETECT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) col__xxx__overwrite_err <= 1'b0;
    else if (state == ST_COLLECT && wr_req && mask[dut__dom__address])
      col__xxx__overwrite_err <= 1'b1;
  end
`endif

  assign col__xxx__valid        = (state == ST_DRAIN);
  assign col__xxx__data         = drain_rdata;
  assign col__xxx__index        = idx;
  assign col__xxx__last         = col__xxx__valid & last_idx;
  assign col__xxx__done         = (state == ST_DONE);
  assign col__xxx__written_mask = mask;

endmodule
